rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Round-robin, packet-locking arbiter that sits directly upstream of the `mux` block. It drives the mux `sel` vector with a registered one-hot grant, chosen among M requesters. The grant stays locked to one requester until that requester's last beat is accepted downstream. Rotating priority gives every persistent requester a grant within M packets.

## Interface
Parameters:
- M, default 2: number of requesters; equals the mux M. Any value ≥ 2; non-powers-of-two are allowed.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- nreset  input  1  reset; asynchronous assert, active-low
- req  input  M  per-requester request; req[i] high means requester i has a beat available
- last  input  1  tail marker for the beat of the currently granted requester
- ready  input  1  downstream accepts the current beat
- grant  output  M  registered one-hot grant, or all-zero; connects to mux `sel`
- valid  output  1  beat presented downstream: |(grant & req)
- ack  output  M  per-requester accept: grant & req & {M{ready}}

## Operation
- State: `busy` (1 bit), `grant` (M bits, registered), `ptr` (clog2(M) bits, minimum 1 bit).
- `ptr` is the index of the highest-priority requester. Priority decreases cyclically: ptr, ptr+1, …, M-1, 0, …, ptr-1.
- Pick function: the first i in that cyclic order with req[i]=1. Returns one-hot, or zero if req=0.
- IDLE (busy=0):
  - grant=0, so valid=0 and ack=0.
  - If req≠0: grant <= pick(req, ptr), busy <= 1.
- BUSY (busy=1):
  - A beat transfers when valid && ready.
  - Transfer with last=0: no state change.
  - Transfer with last=1 (release):
    - ptr <= (granted index + 1) mod M; index M-1 wraps to 0.
    - Compute nxt = pick(req & ~grant, granted index + 1).
    - If nxt≠0: grant <= nxt and stay BUSY (back-to-back, no bubble).
    - Otherwise, if req[granted] is still high: re-grant the same requester (only requester active).
    - Otherwise: grant <= 0, busy <= 0.
  - Granted requester deasserts req without a transfer: grant is held (locked), valid=0. Other requests are ignored until a last beat transfers.
  - ready=0: grant, busy and ptr all hold.
- `last` is ignored when no transfer occurs.
- `grant` is never multi-hot. This is an invariant the bench must check on every cycle.

## Timing
- Reset values: grant=0, valid=0, ack=0, busy=0, ptr=0. These apply asynchronously on nreset low, including in the middle of a packet.
- After nreset deasserts, the first rising edge with req≠0 loads the grant.
- Request-to-grant latency: 1 cycle. req is sampled at edge k; grant, valid and ack are visible after edge k.
- valid and ack are combinational from registered grant and live req/ready. No combinational path from req to grant.
- Back-to-back packets: a release at edge k makes the next grant visible after edge k, so there are zero idle cycles between packets.
- Throughput: one beat per cycle while ready=1 and the granted req stays high.

## Test plan
- Reset: hold nreset=0 with req=all-ones, then release. Required: grant=0, valid=0, ack=0 while in reset. With M=3, grant=3'b001 one cycle after release.
- Fairness: M=4, req=4'b0101 constant, ready=1, last=1. Required grant sequence 0001, 0100, 0001, 0100, …, with ack matching grant every cycle.
- Packet lock: M=2, req=2'b11, ready=1, last high only on the 3rd beat of requester 0. Required: grant=01 for exactly 3 cycles, then 10 on the next cycle with no idle cycle. A requester-0 req drop mid-packet keeps grant=01 with valid=0.
- Backpressure: while granted, drive ready=0 for 5 cycles. Required: grant and ptr unchanged, valid=1, ack=0 throughout. The beat transfers on the cycle ready returns.
- Wrap: M=3, single packets from requesters 2 then 0 and 1 all pending. Required: after the release of 2, ptr wraps to 0 and the next grant is 001, then 010.
- Async reset mid-packet: M=4, grant=0100 in the middle of a packet, then pulse nreset low between edges. Required: grant=0 immediately, without waiting for an edge. After release with req=1111, grant=0001.

Source files
------------

// File: rtl/rr_arbiter_if.sv
// Handshake bundle between M requesters, the round-robin arbiter and the downstream mux.
// Latency: none, this is a plain signal bundle.
// Backpressure: ready flows from downstream to the arbiter, and ack flows back per requester.
// Ports:
//   req[M]   requester i has a beat available
//   last     tail marker for the granted requester's current beat
//   ready    downstream accepts the current beat
//   grant[M] registered one-hot grant, drives the mux sel
//   valid    a beat is presented downstream
//   ack[M]   per-requester accept strobe
interface rr_arbiter_if #(
    parameter int M = 2
);
    logic [M-1:0] req;
    logic         last;
    logic         ready;
    logic [M-1:0] grant;
    logic         valid;
    logic [M-1:0] ack;

    // Requester and downstream side: drives requests and ready, observes grant.
    modport master (
        output req,
        output last,
        output ready,
        input  grant,
        input  valid,
        input  ack
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  last,
        input  ready,
        output grant,
        output valid,
        output ack
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin, packet-locking arbiter that drives the downstream mux sel with a one-hot grant.
// Latency: 1 cycle from req to grant. valid and ack are combinational from grant, req and ready.
// Backpressure: with ready=0 the grant, the pointer and the state all hold. A release on a last beat moves
//               straight to the next requester with no idle cycle.
// Ports:
//   clk     rising-edge clock
//   nreset  asynchronous active-low reset
//   bus     rr_arbiter_if slave: req/last/ready in, grant/valid/ack out
module rr_arbiter #(
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         nreset,
    rr_arbiter_if.slave  bus
);
    localparam int PW = (M > 2) ? $clog2(M) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   grant_q, grant_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  gidx;      // index of the currently granted requester
    logic [PW-1:0]  nidx;      // gidx + 1, wrapping M-1 to 0
    logic [M-1:0]   nxt;       // candidate successor on a release
    logic           valid;
    logic           xfer;

    // Cyclic-priority pick. The candidate at rank 0 is p, then p+1, and so on. The requester with the lowest rank wins.
    // The loop uses constant bounds, so every index is static after unrolling.
    function automatic logic [M-1:0] pick(input logic [M-1:0] r, input logic [PW-1:0] p);
        logic [M-1:0] best;
        int           best_rank;
        int           rank;
        best      = '0;
        best_rank = M;
        for (int i = 0; i < M; i++) begin
            rank = i - int'(p);
            if (rank < 0) begin
                rank = rank + M;
            end
            if (r[i] && (rank < best_rank)) begin
                best_rank = rank;
                best      = '0;
                best[i]   = 1'b1;
            end
        end
        return best;
    endfunction

    assign valid     = |(grant_q & bus.req);
    assign xfer      = valid & bus.ready;
    assign bus.grant = grant_q;
    assign bus.valid = valid;
    assign bus.ack   = grant_q & bus.req & {M{bus.ready}};

    always_comb begin
        gidx = '0;
        for (int i = 0; i < M; i++) begin
            if (grant_q[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign nidx = (int'(gidx) == M - 1) ? '0 : gidx + PW'(1);
    // The releasing requester is masked out, so it wins again only if nobody else is waiting.
    assign nxt  = pick(bus.req & ~grant_q, nidx);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_d = pick(bus.req, ptr_q);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The grant is locked until a last beat transfers. A req drop or a missing ready only stalls it.
                if (xfer && bus.last) begin
                    ptr_d = nidx;
                    if (|nxt) begin
                        grant_d = nxt;
                    end else if (|(bus.req & grant_q)) begin
                        grant_d = grant_q;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter. It uses one instance each with M=2, 3 and 4.
// Latency: it checks the 1-cycle request-to-grant path and the combinational valid/ack.
// Backpressure: it covers ready stalls, locked grants and async reset in the middle of a packet.
module tb_rr_arbiter;
    logic clk;
    logic nreset;
    int   n_vec;
    int   n_err;

    rr_arbiter_if #(.M(2)) if2 ();
    rr_arbiter_if #(.M(3)) if3 ();
    rr_arbiter_if #(.M(4)) if4 ();

    rr_arbiter #(.M(2)) u_arb2 (.clk(clk), .nreset(nreset), .bus(if2));
    rr_arbiter #(.M(3)) u_arb3 (.clk(clk), .nreset(nreset), .bus(if3));
    rr_arbiter #(.M(4)) u_arb4 (.clk(clk), .nreset(nreset), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       last;
        logic       ready;
        logic [3:0] g;
        logic       v;
        logic [3:0] a;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant must never be multi-hot, so this is checked on every cycle for all instances.
    always @(negedge clk) begin
        chk("onehot2", 32'($countones(if2.grant) <= 1), 32'd1);
        chk("onehot3", 32'($countones(if3.grant) <= 1), 32'd1);
        chk("onehot4", 32'($countones(if4.grant) <= 1), 32'd1);
    end

    task automatic idle_inputs();
        if2.req = '0; if2.last = 1'b0; if2.ready = 1'b0;
        if3.req = '0; if3.last = 1'b0; if3.ready = 1'b0;
        if4.req = '0; if4.last = 1'b0; if4.ready = 1'b0;
    endtask

    // Reset is asserted and released between edges. The task returns 3 time units after a rising edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        nreset = 1'b0;
        idle_inputs();
        @(posedge clk);
        #3;
        nreset = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference for M=4. It tracks the granted index as an integer, or -1 when idle.
    localparam int MM = 4;
    int m_g;
    int m_ptr;

    function automatic int mpick(input logic [3:0] r, input int p);
        for (int k = 0; k < MM; k++) begin
            if (r[(p + k) % MM]) return (p + k) % MM;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic lst, input logic rdy);
        int       n;
        logic [3:0] masked;
        if (m_g < 0) begin
            m_g = mpick(r, m_ptr);
        end else if (r[m_g] && rdy && lst) begin
            m_ptr  = (m_g + 1) % MM;
            masked = r;
            masked[m_g] = 1'b0;
            n = mpick(masked, m_ptr);
            if (n >= 0) m_g = n;
            else if (!r[m_g]) m_g = -1;
        end
    endtask

    initial begin
        logic [3:0] eg;
        logic       ev;
        n_vec  = 0;
        n_err  = 0;
        nreset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);

        // M=3 reset: with requests pending while in reset, the outputs must stay low.
        #2;
        if3.req = 3'b111; if3.ready = 1'b1;
        #1;
        chk("rst3_grant", 32'(if3.grant), 32'd0);
        chk("rst3_valid", 32'(if3.valid), 32'd0);
        chk("rst3_ack",   32'(if3.ack),   32'd0);
        @(posedge clk); #3;
        nreset = 1'b1;
        next_cycle();
        chk("rst3_first_grant", 32'(if3.grant), 32'(3'b001));
        chk("rst3_first_ack",   32'(if3.ack),   32'(3'b001));

        // M=3 wrap: requester 2 releases, then 0 and then 1 are served.
        do_reset();
        if3.ready = 1'b1; if3.last = 1'b1; if3.req = 3'b100;
        #1;
        chk("wrap_idle", 32'(if3.grant), 32'd0);
        next_cycle();
        if3.req = 3'b111;
        #1;
        chk("wrap_g2", 32'(if3.grant), 32'(3'b100));
        chk("wrap_a2", 32'(if3.ack),   32'(3'b100));
        next_cycle();
        chk("wrap_g0", 32'(if3.grant), 32'(3'b001));
        next_cycle();
        chk("wrap_g1", 32'(if3.grant), 32'(3'b010));

        // M=2 packet lock: requester 0 sends 3 beats, then requester 1 follows with no bubble.
        do_reset();
        if2.req = 2'b11; if2.ready = 1'b1; if2.last = 1'b0;
        #1;
        chk("lock_idle", 32'(if2.grant), 32'd0);
        next_cycle();
        for (int b = 1; b <= 3; b++) begin
            if2.last = (b == 3);
            #1;
            chk("lock_g0", 32'(if2.grant), 32'(2'b01));
            chk("lock_a0", 32'(if2.ack),   32'(2'b01));
            next_cycle();
        end
        if2.last = 1'b0;
        #1;
        chk("lock_g1", 32'(if2.grant), 32'(2'b10));
        chk("lock_a1", 32'(if2.ack),   32'(2'b10));
        if2.last = 1'b1;
        next_cycle();
        if2.req = 2'b10; if2.last = 1'b0;
        #1;
        chk("drop_g", 32'(if2.grant), 32'(2'b01));
        chk("drop_v", 32'(if2.valid), 32'd0);
        chk("drop_a", 32'(if2.ack),   32'd0);
        next_cycle();
        chk("drop_hold", 32'(if2.grant), 32'(2'b01));

        // M=4 table: each row gives the inputs for a cycle and the outputs expected before that cycle's edge.
        tbl[0]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0101, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0101, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[3]  = '{4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0100, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0101, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[6]  = '{4'b1100, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[7]  = '{4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[8]  = '{4'b0000, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000};
        tbl[9]  = '{4'b0010, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000};
        tbl[10] = '{4'b1010, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[11] = '{4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000};
        tbl[12] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 4'b0010};
        do_reset();
        for (int r = 0; r < 13; r++) begin
            if4.req = tbl[r].req; if4.last = tbl[r].last; if4.ready = tbl[r].ready;
            #1;
            chk($sformatf("tbl%0d_grant", r), 32'(if4.grant), 32'(tbl[r].g));
            chk($sformatf("tbl%0d_valid", r), 32'(if4.valid), 32'(tbl[r].v));
            chk($sformatf("tbl%0d_ack", r),   32'(if4.ack),   32'(tbl[r].a));
            next_cycle();
        end

        // M=4 fairness: two persistent single-beat requesters alternate.
        do_reset();
        if4.req = 4'b0101; if4.ready = 1'b1; if4.last = 1'b1;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            eg = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            chk("fair_grant", 32'(if4.grant), 32'(eg));
            chk("fair_ack",   32'(if4.ack),   32'(eg));
            next_cycle();
        end

        // M=4 backpressure: while ready is low, the grant holds and nothing is accepted.
        do_reset();
        if4.req = 4'b0011; if4.ready = 1'b1; if4.last = 1'b0;
        next_cycle();
        if4.ready = 1'b0; if4.last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_grant", 32'(if4.grant), 32'(4'b0001));
            chk("bp_valid", 32'(if4.valid), 32'd1);
            chk("bp_ack",   32'(if4.ack),   32'd0);
            next_cycle();
        end
        if4.ready = 1'b1;
        #1;
        chk("bp_resume_ack", 32'(if4.ack), 32'(4'b0001));
        next_cycle();
        chk("bp_next_grant", 32'(if4.grant), 32'(4'b0010));

        // M=4 async reset in the middle of a packet: the grant clears without waiting for an edge.
        do_reset();
        if4.req = 4'b0100; if4.ready = 1'b1; if4.last = 1'b0;
        next_cycle();
        #1;
        chk("ar_grant_pre", 32'(if4.grant), 32'(4'b0100));
        next_cycle();
        #2;
        nreset = 1'b0;
        #1;
        chk("ar_grant_rst", 32'(if4.grant), 32'd0);
        chk("ar_valid_rst", 32'(if4.valid), 32'd0);
        chk("ar_ack_rst",   32'(if4.ack),   32'd0);
        if4.req = 4'b1111;
        @(posedge clk); #3;
        nreset = 1'b1;
        next_cycle();
        chk("ar_grant_post", 32'(if4.grant), 32'(4'b0001));

        // M=4 randomized run against the reference model.
        do_reset();
        m_g   = -1;
        m_ptr = 0;
        for (int c = 0; c < 3000; c++) begin
            if4.req   = 4'($urandom_range(0, 15));
            if4.last  = ($urandom_range(0, 2) == 0);
            if4.ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = '0;
            if (m_g >= 0) eg[m_g] = 1'b1;
            ev = |(eg & if4.req);
            chk("rnd_grant", 32'(if4.grant), 32'(eg));
            chk("rnd_valid", 32'(if4.valid), 32'(ev));
            chk("rnd_ack",   32'(if4.ack),   32'(eg & if4.req & {4{if4.ready}}));
            model_step(if4.req, if4.last, if4.ready);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
